// File: rtl/circle_draw.sv
// Midpoint circle rasteriser: walks one octant and emits the eight symmetric points, one per clock.
// Optional clipping of off-screen points is enabled by defining CIRCLE_CLIP_EN.
module circle_draw #(
    parameter int unsigned SCR_W = 160,
    parameter int unsigned SCR_H = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] xc,
    input  logic [6:0] yc,
    input  logic [6:0] r,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       plt,
    output logic       busy,
    output logic       done
);

    // The screen must fit the 8b/7b coordinate outputs.
    if (SCR_W > 256 || SCR_H > 128) begin : g_bad_size
        $error("circle_draw: screen size does not fit the coordinate outputs");
    end

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StPlot,
        StUpdate,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [7:0]        cx_q, cx_d;
    logic [6:0]        cy_q, cy_d;
    logic [6:0]        px_q, px_d;
    logic [6:0]        py_q, py_d;
    logic signed [10:0] d_q, d_d;
    logic [2:0]        oct_q, oct_d;

    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic       plt_q, plt_d;
    logic       done_q, done_d;

    // Octant selection: bit 2 swaps the roles of px/py, bits 0/1 negate the x/y offsets.
    logic [6:0] off_x, off_y;

    always_comb begin
        off_x = oct_q[2] ? py_q : px_q;
        off_y = oct_q[2] ? px_q : py_q;
    end

`ifdef CIRCLE_CLIP_EN
    localparam logic signed [8:0] ScrWS = 9'(SCR_W);
    localparam logic signed [8:0] ScrHS = 9'(SCR_H);

    logic signed [8:0] sum_x, sum_y;
    logic              in_range;

    always_comb begin
        sum_x = oct_q[0] ? $signed({1'b0, cx_q}) - $signed({2'b00, off_x})
                         : $signed({1'b0, cx_q}) + $signed({2'b00, off_x});
        sum_y = oct_q[1] ? $signed({2'b00, cy_q}) - $signed({2'b00, off_y})
                         : $signed({2'b00, cy_q}) + $signed({2'b00, off_y});
        // Sums past +255 read as negative here, which is off-screen either way.
        in_range = !sum_x[8] && !sum_y[8] && (sum_x < ScrWS) && (sum_y < ScrHS);
    end
`else
    logic [7:0] sum_x;
    logic [6:0] sum_y;

    always_comb begin
        sum_x = oct_q[0] ? cx_q - {1'b0, off_x} : cx_q + {1'b0, off_x};
        sum_y = oct_q[1] ? cy_q - off_y : cy_q + off_y;
    end
`endif

    // Iteration update, evaluated every cycle but only committed in StUpdate.
    logic signed [7:0]  diff;
    logic signed [10:0] d_upd;
    logic [8:0]         px_nxt, py_nxt;
    logic               more;

    always_comb begin
        diff   = $signed({1'b0, px_q}) - $signed({1'b0, py_q});
        px_nxt = {2'b00, px_q} + 9'd1;
        if (d_q[10]) begin
            d_upd  = d_q + $signed({2'b00, px_q, 2'b00}) + 11'sd6;
            py_nxt = {2'b00, py_q};
        end else begin
            d_upd  = d_q + $signed({diff[7], diff, 2'b00}) + 11'sd10;
            py_nxt = {2'b00, py_q} - 9'd1;
        end
        // Signed so that py stepping below zero (r=0) ends the walk.
        more = $signed(px_nxt) <= $signed(py_nxt);
    end

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        px_d    = px_q;
        py_d    = py_q;
        d_d     = d_q;
        oct_d   = oct_q;
        x_d     = x_q;
        y_d     = y_q;
        plt_d   = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cx_d    = xc;
                    cy_d    = yc;
                    py_d    = r;
                    state_d = StInit;
                end
            end
            StInit: begin
                px_d    = 7'd0;
                d_d     = 11'sd3 - $signed({3'b000, py_q, 1'b0});
                oct_d   = 3'd0;
                state_d = StPlot;
            end
            StPlot: begin
                x_d = sum_x[7:0];
                y_d = sum_y[6:0];
`ifdef CIRCLE_CLIP_EN
                plt_d = in_range;
`else
                plt_d = 1'b1;
`endif
                oct_d = oct_q + 3'd1;
                if (oct_q == 3'd7) begin
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                d_d  = d_upd;
                px_d = px_nxt[6:0];
                py_d = py_nxt[6:0];
                if (more) begin
                    oct_d   = 3'd0;
                    state_d = StPlot;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cx_q    <= 8'd0;
            cy_q    <= 7'd0;
            px_q    <= 7'd0;
            py_q    <= 7'd0;
            d_q     <= 11'sd0;
            oct_q   <= 3'd0;
            x_q     <= 8'd0;
            y_q     <= 7'd0;
            plt_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            px_q    <= px_d;
            py_q    <= py_d;
            d_q     <= d_d;
            oct_q   <= oct_d;
            x_q     <= x_d;
            y_q     <= y_d;
            plt_q   <= plt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        x    = x_q;
        y    = y_q;
        plt  = plt_q;
        done = done_q;
        busy = (state_q == StInit) || (state_q == StPlot) || (state_q == StUpdate);
    end

endmodule
